// File: rtl/wb_timeout_bridge_pkg.sv
// Shared Zet bus definitions for the timeout bridge: FSM encoding, address width,
// default abort data and the saturating error-count helper.
package wb_timeout_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          ADR_W        = 20;
    localparam logic [15:0] ERR_DATA_DEF = 16'hFFFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/wb_timeout_bridge_if.sv
// Wishbone signal bundle for both sides of the bridge: CPU side (s_*) and switch side (m_*).
interface wb_timeout_bridge_if;
    import wb_timeout_bridge_pkg::*;

    logic [15:0]      s_dat_i;
    logic [15:0]      s_dat_o;
    logic [ADR_W:1]   s_adr_i;
    logic [1:0]       s_sel_i;
    logic             s_we_i;
    logic             s_cyc_i;
    logic             s_stb_i;
    logic             s_ack_o;
    logic [15:0]      m_dat_o;
    logic [ADR_W:1]   m_adr_o;
    logic [1:0]       m_sel_o;
    logic             m_we_o;
    logic             m_cyc_o;
    logic             m_stb_o;
    logic [15:0]      m_dat_i;
    logic             m_ack_i;

    // Bridge view: slave to the CPU, master towards the switch.
    modport slave (
        input  s_dat_i, s_adr_i, s_sel_i, s_we_i, s_cyc_i, s_stb_i, m_dat_i, m_ack_i,
        output s_dat_o, s_ack_o, m_dat_o, m_adr_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o
    );

    // Environment view: drives the CPU requests and the switch responses.
    modport master (
        output s_dat_i, s_adr_i, s_sel_i, s_we_i, s_cyc_i, s_stb_i, m_dat_i, m_ack_i,
        input  s_dat_o, s_ack_o, m_dat_o, m_adr_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o
    );

endinterface

// File: rtl/wb_wdog_cnt.sv
// Watchdog counter: clear/enable, saturates at its maximum, flags terminal count TIMEOUT-1.
// TIMEOUT of 0 keeps the terminal-count flag low forever.
module wb_wdog_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             CW      = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TC_VAL  = (TIMEOUT == 0) ? {CW{1'b0}} : CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  MAX_VAL = {CW{1'b1}};

    logic [CW-1:0] cnt_r;

    // Count register; the saturation guard means it can never wrap back to the terminal value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && (cnt_r != MAX_VAL)) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tc = (TIMEOUT != 0) && (cnt_r == TC_VAL);

endmodule

// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone bridge between the Zet CPU and the address switch, with a bus
// watchdog that terminates hung cycles with ERR_DATA and logs the fault.
module wb_timeout_bridge
    import wb_timeout_bridge_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [15:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    wb_timeout_bridge_if.slave bus,
    output logic             err_o,
    output logic [ADR_W:1]   err_adr_o,
    output logic             err_we_o,
    output logic [7:0]       err_cnt_o,
    input  logic             err_clr_i
);

    state_e          state_r, state_s;
    logic            accept_s, ack_s, timeout_s, cnt_en_s, tc_s;
    logic            req_r, s_ack_r, m_we_r, err_r, err_we_r;
    logic [15:0]     s_dat_r, m_dat_r;
    logic [ADR_W:1]  m_adr_r, err_adr_r;
    logic [1:0]      m_sel_r;
    logic [7:0]      err_cnt_r;

    wb_wdog_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .clr   (accept_s),
        .en    (cnt_en_s),
        .tc    (tc_s)
    );

    // Next-state and per-cycle event decode; a slave ack takes priority over the watchdog.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        ack_s     = 1'b0;
        timeout_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.s_cyc_i && bus.s_stb_i) begin
                    accept_s = 1'b1;
                    state_s  = ST_BUSY;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.m_ack_i) begin
                    ack_s     = 1'b1;
                    state_s   = ST_DONE;
                end else if (tc_s) begin
                    timeout_s = 1'b1;
                    state_s   = ST_DONE;
                end else if (!bus.s_cyc_i) begin
                    state_s   = ST_IDLE;
                end else begin
                    cnt_en_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, bus output and error-log registers; outputs are decoded from the next state.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_r   <= ST_IDLE;
            req_r     <= 1'b0;
            s_ack_r   <= 1'b0;
            s_dat_r   <= 16'h0000;
            m_dat_r   <= 16'h0000;
            m_adr_r   <= {ADR_W{1'b0}};
            m_sel_r   <= 2'b00;
            m_we_r    <= 1'b0;
            err_r     <= 1'b0;
            err_adr_r <= {ADR_W{1'b0}};
            err_we_r  <= 1'b0;
            err_cnt_r <= 8'd0;
        end else begin
            state_r <= state_s;
            req_r   <= (state_s == ST_BUSY);
            s_ack_r <= (state_s == ST_DONE);
            if (accept_s) begin
                m_adr_r <= bus.s_adr_i;
                m_sel_r <= bus.s_sel_i;
                m_dat_r <= bus.s_dat_i;
                m_we_r  <= bus.s_we_i;
            end
            if (ack_s) begin
                s_dat_r <= bus.m_dat_i;
            end else if (timeout_s) begin
                s_dat_r <= ERR_DATA;
            end
            // A timeout in the same cycle as a clear restarts the count at one.
            if (timeout_s) begin
                err_r     <= 1'b1;
                err_adr_r <= m_adr_r;
                err_we_r  <= m_we_r;
                err_cnt_r <= err_clr_i ? 8'd1 : sat_inc8(err_cnt_r);
            end else if (err_clr_i) begin
                err_r     <= 1'b0;
                err_cnt_r <= 8'd0;
            end
        end
    end

    assign bus.s_dat_o = s_dat_r;
    assign bus.s_ack_o = s_ack_r;
    assign bus.m_dat_o = m_dat_r;
    assign bus.m_adr_o = m_adr_r;
    assign bus.m_sel_o = m_sel_r;
    assign bus.m_we_o  = m_we_r;
    assign bus.m_cyc_o = req_r;
    assign bus.m_stb_o = req_r;
    assign err_o       = err_r;
    assign err_adr_o   = err_adr_r;
    assign err_we_o    = err_we_r;
    assign err_cnt_o   = err_cnt_r;

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Scoreboard bench for wb_timeout_bridge: expected CPU responses and error-log state are
// queued as each request is issued and checked when s_ack_o appears.
module tb_wb_timeout_bridge;
    import wb_timeout_bridge_pkg::*;

    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           err_o, err_we_o, err_clr;
    logic [20:1]    err_adr_o;
    logic [7:0]     err_cnt_o;

    wb_timeout_bridge_if bus();

    wb_timeout_bridge #(.TIMEOUT(TO), .ERR_DATA(16'hFFFF)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus),
        .err_o      (err_o),
        .err_adr_o  (err_adr_o),
        .err_we_o   (err_we_o),
        .err_cnt_o  (err_cnt_o),
        .err_clr_i  (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dat;
        logic        err;
        logic [7:0]  cnt;
        logic [20:1] adr;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mdl_err = 1'b0;
    logic [7:0]  mdl_cnt = 8'd0;
    logic [20:1] mdl_adr = 20'h0;
    logic        mdl_we  = 1'b0;

    function automatic logic [87:0] all_outs();
        return {bus.s_ack_o, bus.s_dat_o, bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, bus.m_sel_o,
                bus.m_adr_o, bus.m_dat_o, err_o, err_adr_o, err_we_o, err_cnt_o};
    endfunction

    task automatic idle_bus();
        bus.s_dat_i = 16'h0; bus.s_adr_i = 20'h0; bus.s_sel_i = 2'b00; bus.s_we_i = 1'b0;
        bus.s_cyc_i = 1'b0;  bus.s_stb_i = 1'b0;  bus.m_dat_i = 16'h0; bus.m_ack_i = 1'b0;
        err_clr = 1'b0;
    endtask

    // Expected outcome of one transfer; timed_out transfers update the error-log model.
    task automatic push_exp(input logic [20:1] adr, input logic we, input bit timed_out,
                            input logic [15:0] rdat, input bit clr);
        exp_t e;
        if (timed_out) begin
            mdl_err = 1'b1;
            mdl_cnt = clr ? 8'd1 : ((mdl_cnt == 8'd255) ? 8'd255 : mdl_cnt + 8'd1);
            mdl_adr = adr;
            mdl_we  = we;
            e.dat   = 16'hFFFF;
        end else begin
            e.dat   = rdat;
        end
        e.err = mdl_err; e.cnt = mdl_cnt; e.adr = mdl_adr; e.we = mdl_we;
        sb.push_back(e);
    endtask

    // Drives one CPU request from a negedge and plays the slave (ack after lat stb cycles, 0 = never).
    task automatic run_xfer(input logic [20:1] adr, input logic we, input logic [1:0] sel,
                            input logic [15:0] wdat, input int lat, input logic [15:0] rdat,
                            input int clr_at, input int drop_at, input bit hold, input int max_cyc,
                            output bit ack_seen, output int ack_cyc, output int stb_cyc,
                            output logic [15:0] got, output logic [20:1] o_adr, output logic o_we,
                            output logic [1:0] o_sel, output logic [15:0] o_dat);
        ack_seen = 1'b0; ack_cyc = 0; stb_cyc = 0; got = 16'h0;
        o_adr = 20'h0; o_we = 1'b0; o_sel = 2'b00; o_dat = 16'h0;
        bus.s_adr_i = adr; bus.s_we_i = we; bus.s_sel_i = sel; bus.s_dat_i = wdat;
        bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            bus.m_ack_i = 1'b0; bus.m_dat_i = 16'h0; err_clr = 1'b0;
            if (bus.m_stb_o) begin
                stb_cyc++;
                if (stb_cyc == 1) begin
                    o_adr = bus.m_adr_o; o_we = bus.m_we_o; o_sel = bus.m_sel_o; o_dat = bus.m_dat_o;
                end
                if (lat > 0 && stb_cyc == lat) begin
                    bus.m_ack_i = 1'b1; bus.m_dat_i = rdat;
                end
                if (clr_at > 0 && stb_cyc == clr_at) err_clr = 1'b1;
                if (drop_at > 0 && stb_cyc == drop_at) begin
                    bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
                end
            end
            if (bus.s_ack_o) begin
                ack_seen = 1'b1; ack_cyc = c; got = bus.s_dat_o;
                break;
            end
        end
        if (!hold) begin
            bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
            if (ack_seen) @(negedge clk);
        end
    endtask

    bit          ack;
    int          acyc, scyc;
    logic [15:0] got, odat;
    logic [20:1] oadr;
    logic        owe;
    logic [1:0]  osel;
    exp_t        e;

    task automatic test_reset();
        n_cmp++;
        if (all_outs() !== 88'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
    endtask

    task automatic test_read();
        logic [20:1] adrs [3] = '{20'h00010, 20'hFFFFF, 20'h5A5A5};
        logic [15:0] dats [3] = '{16'h1234, 16'h8001, 16'h0000};
        int          lats [3] = '{3, 1, 5};
        for (int i = 0; i < 3; i++) begin
            push_exp(adrs[i], 1'b0, 1'b0, dats[i], 1'b0);
            run_xfer(adrs[i], 1'b0, 2'b11, 16'h0, lats[i], dats[i], 0, 0, 1'b0, 30,
                     ack, acyc, scyc, got, oadr, owe, osel, odat);
            e = sb.pop_front();
            n_cmp++;
            if (!ack || acyc != lats[i] + 1) begin
                n_bad++; $display("FAIL read_latency[%0d]: ack=%0d cyc=%0d want cyc=%0d", i, ack, acyc, lats[i] + 1);
            end
            n_cmp++;
            if (got !== e.dat) begin n_bad++; $display("FAIL read_data[%0d]: got %h want %h", i, got, e.dat); end
            n_cmp++;
            if (oadr !== adrs[i] || owe !== 1'b0 || osel !== 2'b11) begin
                n_bad++; $display("FAIL read_fwd[%0d]: adr %h we %b sel %b want %h 0 11", i, oadr, owe, osel, adrs[i]);
            end
            n_cmp++;
            if (err_o !== e.err || err_cnt_o !== e.cnt) begin
                n_bad++; $display("FAIL read_err[%0d]: err %b cnt %0d want %b %0d", i, err_o, err_cnt_o, e.err, e.cnt);
            end
        end
    endtask

    task automatic test_timeout();
        push_exp(20'hABCDE, 1'b0, 1'b1, 16'h0, 1'b0);
        run_xfer(20'hABCDE, 1'b0, 2'b10, 16'h0, 0, 16'h0, 0, 0, 1'b0, 30,
                 ack, acyc, scyc, got, oadr, owe, osel, odat);
        e = sb.pop_front();
        n_cmp++;
        if (scyc != TO || !ack || acyc != TO + 1) begin
            n_bad++; $display("FAIL timeout_timing: stb=%0d ack=%0d cyc=%0d want %0d 1 %0d", scyc, ack, acyc, TO, TO + 1);
        end
        n_cmp++;
        if (got !== e.dat) begin n_bad++; $display("FAIL timeout_data: got %h want %h", got, e.dat); end
        n_cmp++;
        if (err_o !== e.err || err_adr_o !== e.adr || err_we_o !== e.we || err_cnt_o !== e.cnt) begin
            n_bad++; $display("FAIL timeout_log: err %b adr %h we %b cnt %0d want %b %h %b %0d",
                              err_o, err_adr_o, err_we_o, err_cnt_o, e.err, e.adr, e.we, e.cnt);
        end
    endtask

    task automatic test_ack_at_tc();
        push_exp(20'h00123, 1'b0, 1'b0, 16'hBEEF, 1'b0);
        run_xfer(20'h00123, 1'b0, 2'b11, 16'h0, TO, 16'hBEEF, 0, 0, 1'b0, 30,
                 ack, acyc, scyc, got, oadr, owe, osel, odat);
        e = sb.pop_front();
        n_cmp++;
        if (!ack || acyc != TO + 1 || got !== e.dat) begin
            n_bad++; $display("FAIL ack_at_tc: ack=%0d cyc=%0d dat %h want cyc %0d dat %h", ack, acyc, got, TO + 1, e.dat);
        end
        n_cmp++;
        if (err_cnt_o !== e.cnt || err_adr_o !== e.adr) begin
            n_bad++; $display("FAIL ack_at_tc_log: cnt %0d adr %h want %0d %h", err_cnt_o, err_adr_o, e.cnt, e.adr);
        end
    endtask

    task automatic test_late_ack();
        push_exp(20'h0F0F0, 1'b1, 1'b1, 16'h0, 1'b0);
        run_xfer(20'h0F0F0, 1'b1, 2'b01, 16'h7777, 0, 16'h0, 0, 0, 1'b1, 30,
                 ack, acyc, scyc, got, oadr, owe, osel, odat);
        e = sb.pop_front();
        n_cmp++;
        if (!ack || got !== e.dat || err_we_o !== e.we || err_cnt_o !== e.cnt) begin
            n_bad++; $display("FAIL late_ack_setup: ack=%0d dat %h we %b cnt %0d want %h %b %0d",
                              ack, got, err_we_o, err_cnt_o, e.dat, e.we, e.cnt);
        end
        bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
        bus.m_ack_i = 1'b1; bus.m_dat_i = 16'h5A5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.m_ack_i = (i == 0);
            n_cmp++;
            if (bus.s_ack_o !== 1'b0 || bus.s_dat_o !== 16'hFFFF || bus.m_stb_o !== 1'b0) begin
                n_bad++; $display("FAIL late_ack_ignored[%0d]: ack %b dat %h stb %b want 0 ffff 0",
                                  i, bus.s_ack_o, bus.s_dat_o, bus.m_stb_o);
            end
        end
        bus.m_ack_i = 1'b0; bus.m_dat_i = 16'h0;
    endtask

    task automatic test_saturate();
        int n_acks = 0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        mdl_err = 1'b0; mdl_cnt = 8'd0;
        n_cmp++;
        if (err_o !== 1'b0 || err_cnt_o !== 8'd0) begin
            n_bad++; $display("FAIL err_clear: err %b cnt %0d want 0 0", err_o, err_cnt_o);
        end
        for (int i = 0; i < 256; i++) begin
            push_exp(20'(i), 1'b0, 1'b1, 16'h0, 1'b0);
            run_xfer(20'(i), 1'b0, 2'b11, 16'h0, 0, 16'h0, 0, 0, 1'b0, 30,
                     ack, acyc, scyc, got, oadr, owe, osel, odat);
            e = sb.pop_front();
            if (ack && got === e.dat) n_acks++;
        end
        n_cmp++;
        if (n_acks != 256) begin n_bad++; $display("FAIL sat_acks: got %0d want 256", n_acks); end
        n_cmp++;
        if (err_cnt_o !== e.cnt || err_o !== 1'b1 || err_adr_o !== e.adr) begin
            n_bad++; $display("FAIL sat_count: cnt %0d err %b adr %h want %0d 1 %h", err_cnt_o, err_o, err_adr_o, e.cnt, e.adr);
        end
        push_exp(20'h33333, 1'b0, 1'b1, 16'h0, 1'b1);
        run_xfer(20'h33333, 1'b0, 2'b11, 16'h0, 0, 16'h0, TO, 0, 1'b0, 30,
                 ack, acyc, scyc, got, oadr, owe, osel, odat);
        e = sb.pop_front();
        n_cmp++;
        if (!ack || err_o !== e.err || err_cnt_o !== e.cnt) begin
            n_bad++; $display("FAIL clr_vs_timeout: ack=%0d err %b cnt %0d want 1 %0d", ack, err_o, err_cnt_o, e.cnt);
        end
    endtask

    task automatic test_abort();
        run_xfer(20'h44444, 1'b0, 2'b11, 16'h0, 0, 16'h0, 0, 2, 1'b0, 14,
                 ack, acyc, scyc, got, oadr, owe, osel, odat);
        n_cmp++;
        if (ack || scyc != 2) begin
            n_bad++; $display("FAIL abort: ack=%0d stb_cycles=%0d want 0 2", ack, scyc);
        end
        n_cmp++;
        if (err_cnt_o !== mdl_cnt || err_adr_o !== mdl_adr) begin
            n_bad++; $display("FAIL abort_log: cnt %0d adr %h want %0d %h", err_cnt_o, err_adr_o, mdl_cnt, mdl_adr);
        end
    endtask

    task automatic test_reset_busy_write();
        bit seen = 1'b0;
        bus.s_adr_i = 20'h77777; bus.s_we_i = 1'b0; bus.s_sel_i = 2'b11;
        bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.m_stb_o !== 1'b1) begin n_bad++; $display("FAIL rst_busy_pre: stb %b want 1", bus.m_stb_o); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (all_outs() !== 88'h0) begin n_bad++; $display("FAIL rst_busy: got %h want 0", all_outs()); end
        rst_n = 1'b1; bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
        mdl_err = 1'b0; mdl_cnt = 8'd0; mdl_adr = 20'h0; mdl_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.s_ack_o) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL rst_busy_noack: ack seen=1 want 0"); end
        push_exp(20'h12345, 1'b1, 1'b0, 16'h0F0F, 1'b0);
        run_xfer(20'h12345, 1'b1, 2'b01, 16'hC3C3, 2, 16'h0F0F, 0, 0, 1'b0, 30,
                 ack, acyc, scyc, got, oadr, owe, osel, odat);
        e = sb.pop_front();
        n_cmp++;
        if (owe !== 1'b1 || osel !== 2'b01 || odat !== 16'hC3C3 || oadr !== 20'h12345) begin
            n_bad++; $display("FAIL write_fwd: we %b sel %b dat %h adr %h want 1 01 c3c3 12345", owe, osel, odat, oadr);
        end
        n_cmp++;
        if (!ack || acyc != 3 || got !== e.dat || err_o !== e.err || err_cnt_o !== e.cnt) begin
            n_bad++; $display("FAIL write_done: ack=%0d cyc=%0d dat %h err %b cnt %0d want 3 %h %b %0d",
                              ack, acyc, got, err_o, err_cnt_o, e.dat, e.err, e.cnt);
        end
    endtask

    task automatic test_back_to_back();
        push_exp(20'h00AAA, 1'b0, 1'b0, 16'h1111, 1'b0);
        push_exp(20'h00BBB, 1'b0, 1'b0, 16'h2222, 1'b0);
        run_xfer(20'h00AAA, 1'b0, 2'b11, 16'h0, 1, 16'h1111, 0, 0, 1'b1, 30,
                 ack, acyc, scyc, got, oadr, owe, osel, odat);
        e = sb.pop_front();
        n_cmp++;
        if (!ack || acyc != 2 || got !== e.dat) begin
            n_bad++; $display("FAIL b2b_first: ack=%0d cyc=%0d dat %h want 2 %h", ack, acyc, got, e.dat);
        end
        run_xfer(20'h00BBB, 1'b0, 2'b11, 16'h0, 1, 16'h2222, 0, 0, 1'b0, 30,
                 ack, acyc, scyc, got, oadr, owe, osel, odat);
        e = sb.pop_front();
        n_cmp++;
        if (!ack || acyc != 3 || got !== e.dat || oadr !== 20'h00BBB) begin
            n_bad++; $display("FAIL b2b_second: ack=%0d period=%0d dat %h adr %h want 3 %h 00bbb", ack, acyc, got, oadr, e.dat);
        end
    endtask

    initial begin
        idle_bus();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_read();
        test_timeout();
        test_ack_at_tc();
        test_late_ack();
        test_saturate();
        test_abort();
        test_reset_busy_write();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
